// File: rtl/rcvr_pkg.sv
// Shared types and constants for the multi-channel serial frame receiver.
// Holds the framing FSM encoding, the error counter width and the synchroniser depth.
package rcvr_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int FERR_CNT_W  = 16;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/rcvr_fifo.sv
// Synchronous FIFO with registered storage; write visible on o_vld the cycle after push.
// Push when full is dropped (o_drop) unless a pop happens in the same cycle; pop when empty is ignored.
module rcvr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_vld,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dat  = r_mem[r_rd_ptr];
    assign o_vld  = !w_empty;
    assign o_fill = r_cnt;
    assign o_drop = i_push && w_full && !w_pop;
endmodule

// File: rtl/rcvr_mc.sv
// Multi-lane serial frame receiver: last-bit strobe at T -> FIFO write T+1 -> o_vld T+2.
// Output is valid/ready; when the FIFO is full a completed word set is dropped and o_ovf latches.
module rcvr_mc
    import rcvr_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_sclk,
    input  logic                          i_fs,
    input  logic [NUM_CH-1:0]             i_d,
    output logic [NUM_CH*WORD_W-1:0]      o_data,
    output logic                          o_vld,
    input  logic                          i_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill,
    output logic                          o_ovf,
    output logic [FERR_CNT_W-1:0]         o_ferr_cnt,
    input  logic                          i_clr
);
    localparam int CW = $clog2(WORD_W + 1);
    localparam int SW = NUM_CH + 2;

    logic [SW-1:0]           r_sync [SYNC_STAGES];
    logic                    r_sclk_prev;
    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_bit_cnt, w_cnt_nxt;
    logic                    r_push;
    logic                    r_ovf;
    logic [FERR_CNT_W-1:0]   r_ferr_cnt;
    logic [SW-1:0]           w_sync;
    logic                    w_sclk, w_fs, w_strobe;
    logic [NUM_CH-1:0]       w_d;
    logic                    w_load, w_shift, w_done, w_ferr, w_drop;
    logic [NUM_CH*WORD_W-1:0] w_word;

    // sclk, fs and data share one synchroniser chain so they stay aligned to each other.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sync[0] <= {i_sclk, i_fs, i_d};
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_sclk   = w_sync[SW-1];
    assign w_fs     = w_sync[SW-2];
    assign w_d      = w_sync[NUM_CH-1:0];
    assign w_strobe = w_sclk && !r_sclk_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_push    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_push    <= w_done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe && w_fs) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_strobe && w_fs) begin
                    // Early frame sync: the partial word is abandoned and a new one starts here.
                    w_ferr    = 1'b1;
                    w_load    = 1'b1;
                    w_cnt_nxt = CW'(1);
                end else if (w_strobe) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_bit_cnt + CW'(1);
                    if (r_bit_cnt == CW'(WORD_W - 1)) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [WORD_W-1:0] r_sh;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_sh <= '0;
            else if (w_load)
                r_sh <= MSB_FIRST ? {{(WORD_W-1){1'b0}}, w_d[k]} : {w_d[k], {(WORD_W-1){1'b0}}};
            else if (w_shift)
                r_sh <= MSB_FIRST ? {r_sh[WORD_W-2:0], w_d[k]} : {w_d[k], r_sh[WORD_W-1:1]};
        end
        assign w_word[k*WORD_W +: WORD_W] = r_sh;
    end

    rcvr_fifo #(
        .WIDTH (NUM_CH*WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_push),
        .i_dat   (w_word),
        .i_pop   (i_rdy),
        .o_dat   (o_data),
        .o_vld   (o_vld),
        .o_fill  (o_fill),
        .o_drop  (w_drop)
    );

    // A new event in the same cycle as i_clr takes precedence over the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf      <= 1'b0;
            r_ferr_cnt <= '0;
        end else begin
            if (w_drop)     r_ovf <= 1'b1;
            else if (i_clr) r_ovf <= 1'b0;
            if (w_ferr) begin
                if (i_clr)                r_ferr_cnt <= FERR_CNT_W'(1);
                else if (r_ferr_cnt != '1) r_ferr_cnt <= r_ferr_cnt + FERR_CNT_W'(1);
            end else if (i_clr) begin
                r_ferr_cnt <= '0;
            end
        end
    end

    assign o_ovf      = r_ovf;
    assign o_ferr_cnt = r_ferr_cnt;
endmodule

// File: tb/tb_rcvr_mc.sv
// Directed bench for rcvr_mc: default 4x16 MSB-first instance plus a 4x8 LSB-first instance.
module tb_rcvr_mc;
    logic        i_clk = 1'b0;
    logic        i_rst_n, i_sclk, i_fs, i_fs2, i_rdy, i_rdy2, i_clr;
    logic [3:0]  i_d;
    logic [63:0] o_data;
    logic        o_vld, o_ovf;
    logic [3:0]  o_fill;
    logic [15:0] o_ferr_cnt;
    logic [31:0] o_data2;
    logic        o_vld2, o_ovf2;
    logic [2:0]  o_fill2;
    logic [15:0] o_ferr2;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    rcvr_mc dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_fs(i_fs), .i_d(i_d),
        .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy), .o_fill(o_fill),
        .o_ovf(o_ovf), .o_ferr_cnt(o_ferr_cnt), .i_clr(i_clr)
    );

    rcvr_mc #(.NUM_CH(4), .WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_fs(i_fs2), .i_d(i_d),
        .o_data(o_data2), .o_vld(o_vld2), .i_rdy(i_rdy2), .o_fill(o_fill2),
        .o_ovf(o_ovf2), .o_ferr_cnt(o_ferr2), .i_clr(i_clr)
    );

    typedef struct {
        logic [63:0] pre;
        int          pre_bits;
        logic [63:0] set;
        logic [63:0] exp_data;
        logic [15:0] exp_ferr;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // sclk is low for 3 cycles with fs/data set up, then rises; returns at the rising edge.
    task automatic drive_bit(input logic fs, input logic fs2, input logic [3:0] d);
        i_sclk = 1'b0;
        i_fs   = fs;
        i_fs2  = fs2;
        i_d    = d;
        repeat (3) @(negedge i_clk);
        i_sclk = 1'b1;
    endtask

    task automatic send_set(input logic [63:0] set, input int nbits, input bit hold_last);
        logic [3:0] d;
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < 4; k++) d[k] = set[k*16 + 15 - i];
            drive_bit(i == 0, 1'b0, d);
            if (!(hold_last && i == nbits - 1)) repeat (3) @(negedge i_clk);
        end
    endtask

    task automatic wait_vld(input string name);
        int n = 0;
        while (!o_vld && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        check(name, o_vld, 1'b1);
    endtask

    task automatic pop1();
        i_rdy = 1'b1;
        @(negedge i_clk);
        i_rdy = 1'b0;
    endtask

    function automatic logic [63:0] wset(input int n);
        logic [15:0] v;
        v = 16'(n);
        return {16'hA000 + v, 16'hB000 + v, 16'hC000 + v, 16'hD000 + v};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_q [$];
        int n;

        vecs[0] = '{64'h0, 0, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 16'd0};
        vecs[1] = '{64'h0, 0, 64'hFFFF_0000_A5A5_8001, 64'hFFFF_0000_A5A5_8001, 16'd0};
        vecs[2] = '{64'hDEAD_BEEF_1234_5678, 7, 64'h1357_9BDF_2468_ACE0, 64'h1357_9BDF_2468_ACE0, 16'd1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0001_7FFE_C33C, 64'h8000_0001_7FFE_C33C, 16'd2};

        i_rst_n = 1'b0; i_sclk = 1'b0; i_fs = 1'b0; i_fs2 = 1'b0; i_d = 4'h0;
        i_rdy = 1'b0; i_rdy2 = 1'b0; i_clr = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_vld", o_vld, 1'b0);
        check("rst_fill", o_fill, 4'd0);
        check("rst_ovf", o_ovf, 1'b0);
        check("rst_ferr", o_ferr_cnt, 16'd0);
        check("rst_data", o_data, 64'h0);

        // Table: single word sets, optionally preceded by a truncated word.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].pre_bits > 0) send_set(vecs[i].pre, vecs[i].pre_bits, 1'b0);
            if (i == 0) begin
                send_set(vecs[i].set, 16, 1'b1);
                repeat (3) @(negedge i_clk);
                check("lat_early", o_vld, 1'b0);
                @(negedge i_clk);
                check("lat_vld", o_vld, 1'b1);
            end else begin
                send_set(vecs[i].set, 16, 1'b0);
            end
            wait_vld($sformatf("v%0d_vld", i));
            check($sformatf("v%0d_data", i), o_data, vecs[i].exp_data);
            check($sformatf("v%0d_ferr", i), o_ferr_cnt, vecs[i].exp_ferr);
            check($sformatf("v%0d_ovf", i), o_ovf, 1'b0);
            repeat (3) @(negedge i_clk);
            check($sformatf("v%0d_hold", i), o_data, vecs[i].exp_data);
            pop1();
            check($sformatf("v%0d_drain", i), o_vld, 1'b0);
            check($sformatf("v%0d_fill", i), o_fill, 4'd0);
        end

        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        check("clr_ferr", o_ferr_cnt, 16'd0);

        // Overflow: nine words with no consumer.
        for (int w = 0; w < 9; w++) send_set(wset(w), 16, 1'b0);
        repeat (5) @(negedge i_clk);
        check("full_fill", o_fill, 4'd8);
        check("full_ovf", o_ovf, 1'b1);
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        check("clr_ovf", o_ovf, 1'b0);

        // Push while full with a pop in the same cycle.
        send_set(wset(9), 16, 1'b1);
        repeat (3) @(negedge i_clk);
        check("pp_head", o_data, wset(0));
        i_rdy = 1'b1;
        @(negedge i_clk);
        i_rdy = 1'b0;
        check("pp_fill", o_fill, 4'd8);
        check("pp_ovf", o_ovf, 1'b0);

        for (int w = 1; w < 8; w++) exp_q.push_back(wset(w));
        exp_q.push_back(wset(9));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), o_data, exp_q[i]);
            pop1();
        end
        check("drain_vld", o_vld, 1'b0);
        check("drain_fill", o_fill, 4'd0);

        // LSB-first 8-bit instance.
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b0, i == 0, {2'b00, (i == 1 || i == 7), (i == 0)});
            repeat (3) @(negedge i_clk);
        end
        n = 0;
        while (!o_vld2 && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        check("lsb_vld", o_vld2, 1'b1);
        check("lsb_data", o_data2, 32'h0000_8201);
        check("lsb_ferr", o_ferr2, 16'd0);
        check("lsb_other_idle", o_vld, 1'b0);
        i_rdy2 = 1'b1;
        @(negedge i_clk);
        i_rdy2 = 1'b0;
        check("lsb_drain", o_vld2, 1'b0);

        // Reset in the middle of a word, with a word already queued.
        send_set(wset(20), 16, 1'b0);
        wait_vld("mr_pre_vld");
        send_set(wset(21), 5, 1'b0);
        i_sclk = 1'b0;
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        check("mr_vld", o_vld, 1'b0);
        check("mr_fill", o_fill, 4'd0);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("mr_ferr", o_ferr_cnt, 16'd0);
        check("mr_vld_after", o_vld, 1'b0);
        send_set(wset(22), 16, 1'b0);
        wait_vld("mr_next_vld");
        check("mr_next_data", o_data, wset(22));
        check("mr_next_ferr", o_ferr_cnt, 16'd0);
        pop1();
        check("mr_drain", o_vld, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
